// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice datapath: envelope states,
// keycode limits and the octave/waveform select types.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_MAX  = 4'd12;

  typedef logic [1:0] octave_t;
  typedef logic [1:0] wave_t;

  // Keycodes 13..15 all mean "no key held".
  function automatic logic key_valid(input logic [3:0] k);
    return k <= KEY_MAX;
  endfunction

endpackage

// File: rtl/env_ramp.sv
// Saturating up/down step unit: moves env by step towards full scale (dir=1)
// or towards zero (dir=0) when en is high, and flags when the limit is hit.
module env_ramp #(
  parameter int W = 8
) (
  input  logic [W-1:0] env,
  input  logic [W-1:0] step,
  input  logic         dir,
  input  logic         en,
  output logic [W-1:0] next_env,
  output logic         at_limit
);

  localparam logic [W-1:0] ENV_MAX = '1;

  logic [W:0] sum;

  always_comb begin
    sum      = {1'b0, env} + {1'b0, step};
    next_env = env;
    if (en) begin
      if (dir) begin
        next_env = sum[W] ? ENV_MAX : sum[W-1:0];
      end else begin
        // Compare before subtracting so the result never wraps below zero.
        next_env = (env > step) ? (env - step) : '0;
      end
    end
    at_limit = dir ? (next_env == ENV_MAX) : (next_env == '0);
  end

endmodule

// File: rtl/note_scheduler.sv
// Single-voice note scheduler: latches the active key, runs the
// attack/sustain/release envelope on sample_tick, and keeps octave/wave selects.
module note_scheduler
  import synth_pkg::*;
#(
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       keycode,
  input  logic             mode_edge,
  input  logic             sound_edge,
  input  logic             sample_tick,
  output logic [3:0]       note,
  output octave_t          octave,
  output wave_t            wave_sel,
  output logic [ENV_W-1:0] env,
  output logic             note_on,
  output logic             busy,
  output env_state_t       state
);

  env_state_t       state_d;
  logic [3:0]       note_d;
  logic             note_on_d;
  logic             key_ok;
  logic             ramp_en;
  logic             ramp_up;
  logic [ENV_W-1:0] ramp_step;
  logic [ENV_W-1:0] env_d;
  logic             at_limit;

  assign key_ok    = key_valid(keycode);
  assign ramp_up   = (state == ATTACK);
  assign ramp_en   = sample_tick && ((state == ATTACK) || (state == RELEASE));
  assign ramp_step = ramp_up ? ENV_W'(ATTACK_STEP) : ENV_W'(RELEASE_STEP);

  env_ramp #(.W(ENV_W)) u_env_ramp (
    .env      (env),
    .step     (ramp_step),
    .dir      (ramp_up),
    .en       (ramp_en),
    .next_env (env_d),
    .at_limit (at_limit)
  );

  // Release beats a key change, which beats the envelope threshold.
  always_comb begin
    state_d   = state;
    note_d    = note;
    note_on_d = 1'b0;
    case (state)
      IDLE: begin
        if (key_ok) begin
          state_d   = ATTACK;
          note_d    = keycode;
          note_on_d = 1'b1;
        end
      end
      ATTACK: begin
        if (!key_ok) begin
          state_d = RELEASE;
        end else if (keycode != note) begin
          note_d    = keycode;
          note_on_d = 1'b1;
        end else if (ramp_en && at_limit) begin
          state_d = SUSTAIN;
        end
      end
      SUSTAIN: begin
        if (!key_ok) begin
          state_d = RELEASE;
        end else if (keycode != note) begin
          note_d    = keycode;
          note_on_d = 1'b1;
        end
      end
      RELEASE: begin
        if (key_ok) begin
          state_d   = ATTACK;
          note_d    = keycode;
          note_on_d = 1'b1;
        end else if (ramp_en && at_limit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      note     <= 4'd0;
      octave   <= '0;
      wave_sel <= '0;
      env      <= '0;
      note_on  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      note     <= note_d;
      note_on  <= note_on_d;
      busy     <= (state_d != IDLE);
      env      <= env_d;
      octave   <= octave + octave_t'(mode_edge);
      wave_sel <= wave_sel + wave_t'(sound_edge);
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: a vector table, hand-written envelope sequences
// and a randomized run checked against a behavioural model.
module tb_note_scheduler;
  import synth_pkg::*;

  localparam int ENV_W = 8;
  localparam int EMAX  = 255;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       keycode;
  logic             mode_edge, sound_edge, sample_tick;
  logic [3:0]       note;
  octave_t          octave;
  wave_t            wave_sel;
  logic [ENV_W-1:0] env;
  logic             note_on, busy;
  env_state_t       state;

  always #5 clk = ~clk;

  note_scheduler #(.ENV_W(ENV_W), .ATTACK_STEP(64), .RELEASE_STEP(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .keycode     (keycode),
    .mode_edge   (mode_edge),
    .sound_edge  (sound_edge),
    .sample_tick (sample_tick),
    .note        (note),
    .octave      (octave),
    .wave_sel    (wave_sel),
    .env         (env),
    .note_on     (note_on),
    .busy        (busy),
    .state       (state)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [ENV_W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  env_state_t m_state = IDLE;
  int m_env = 0, m_note = 0, m_oct = 0, m_wave = 0;
  bit m_on = 0;

  task automatic model_step(input bit r, input int kc, input bit me, input bit se, input bit tk);
    bit valid;
    int new_env;
    if (r) begin
      m_state = IDLE; m_env = 0; m_note = 0; m_oct = 0; m_wave = 0; m_on = 0;
      return;
    end
    valid   = (kc <= 12);
    new_env = m_env;
    if (tk && m_state == ATTACK)  new_env = (m_env + 64 > EMAX) ? EMAX : m_env + 64;
    if (tk && m_state == RELEASE) new_env = (m_env - 32 < 0) ? 0 : m_env - 32;
    m_on = 0;
    case (m_state)
      IDLE:    if (valid) begin m_note = kc; m_on = 1; m_state = ATTACK; end
      ATTACK:  if (!valid) m_state = RELEASE;
               else if (kc != m_note) begin m_note = kc; m_on = 1; end
               else if (tk && new_env == EMAX) m_state = SUSTAIN;
      SUSTAIN: if (!valid) m_state = RELEASE;
               else if (kc != m_note) begin m_note = kc; m_on = 1; end
      default: if (valid) begin m_note = kc; m_on = 1; m_state = ATTACK; end
               else if (tk && new_env == 0) m_state = IDLE;
    endcase
    m_env  = new_env;
    m_oct  = (m_oct + int'(me)) % 4;
    m_wave = (m_wave + int'(se)) % 4;
  endtask

  // ---------------- driver ----------------
  task automatic apply(input bit r, input logic [3:0] kc, input bit me, input bit se, input bit tk);
    @(negedge clk);
    rst = r; keycode = kc; mode_edge = me; sound_edge = se; sample_tick = tk;
    @(posedge clk);
    model_step(r, int'(kc), me, se, tk);
    #1;
    chk("model_state",   int'(state),    int'(m_state));
    chk("model_env",     int'(env),      m_env);
    chk("model_note",    int'(note),     m_note);
    chk("model_note_on", int'(note_on),  int'(m_on));
    chk("model_octave",  int'(octave),   m_oct);
    chk("model_wave",    int'(wave_sel), m_wave);
    chk("model_busy",    int'(busy),     int'(m_state != IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r; logic [3:0] kc; bit me; bit se; bit tk;
    env_state_t st; int env; int note; bit on; int oct; int wave;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit r, input logic [3:0] kc, input bit tk,
                         input env_state_t st, input int e, input int n, input bit on);
    vec_t v;
    v.r = r; v.kc = kc; v.me = 0; v.se = 0; v.tk = tk;
    v.st = st; v.env = e; v.note = n; v.on = on; v.oct = 0; v.wave = 0;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; keycode = KEY_NONE; mode_edge = 0; sound_edge = 0; sample_tick = 0;

    add_vec(1, 4'd15, 0, IDLE,    0,   0, 0);
    add_vec(0, 4'd4,  0, ATTACK,  0,   4, 1);
    add_vec(0, 4'd4,  1, ATTACK,  64,  4, 0);
    add_vec(0, 4'd4,  1, ATTACK,  128, 4, 0);
    add_vec(0, 4'd4,  1, ATTACK,  192, 4, 0);
    add_vec(0, 4'd4,  1, SUSTAIN, 255, 4, 0);
    add_vec(0, 4'd15, 0, RELEASE, 255, 4, 0);
    for (int i = 1; i <= 7; i++) add_vec(0, 4'd15, 1, RELEASE, 255 - 32 * i, 4, 0);
    add_vec(0, 4'd15, 1, IDLE,    0,   4, 0);
    add_vec(0, 4'd13, 0, IDLE,    0,   4, 0);
    add_vec(0, 4'd14, 1, IDLE,    0,   4, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].kc, vecs[i].me, vecs[i].se, vecs[i].tk);
      chk($sformatf("vec%0d_state", i),   int'(state),    int'(vecs[i].st));
      chk($sformatf("vec%0d_env", i),     int'(env),      vecs[i].env);
      chk($sformatf("vec%0d_note", i),    int'(note),     vecs[i].note);
      chk($sformatf("vec%0d_note_on", i), int'(note_on),  int'(vecs[i].on));
      chk($sformatf("vec%0d_octave", i),  int'(octave),   vecs[i].oct);
      chk($sformatf("vec%0d_wave", i),    int'(wave_sel), vecs[i].wave);
      chk($sformatf("vec%0d_busy", i),    int'(busy),     int'(vecs[i].st != IDLE));
    end

    // Legato retrigger during ATTACK, then retrigger of the same note in RELEASE.
    apply(0, 4'd4, 0, 0, 0);
    apply(0, 4'd4, 0, 0, 1);
    apply(0, 4'd4, 0, 0, 1);
    chk("atk_env128", int'(env), 128);
    apply(0, 4'd7, 0, 0, 0);
    chk("retrig_note", int'(note), 7);
    chk("retrig_pulse", int'(note_on), 1);
    chk("retrig_env_kept", int'(env), 128);
    chk("retrig_state", int'(state), int'(ATTACK));
    apply(0, 4'd7, 0, 0, 0);
    chk("retrig_pulse_one_cycle", int'(note_on), 0);
    apply(0, 4'd7, 0, 0, 1);
    chk("legato_env192", int'(env), 192);
    apply(0, 4'd7, 0, 0, 1);
    chk("legato_env255", int'(env), 255);
    chk("legato_sustain", int'(state), int'(SUSTAIN));
    apply(0, 4'd15, 0, 0, 0);
    for (int i = 1; i <= 5; i++) exp_q.push_back(ENV_W'(255 - 32 * i));
    while (exp_q.size() > 0) begin
      apply(0, 4'd15, 0, 0, 1);
      chk("release_env", int'(env), int'(exp_q.pop_front()));
    end
    apply(0, 4'd7, 0, 0, 0);
    chk("rel_retrig_state", int'(state), int'(ATTACK));
    chk("rel_retrig_pulse", int'(note_on), 1);
    chk("rel_retrig_env", int'(env), 95);
    apply(0, 4'd7, 0, 0, 1);
    chk("rel_retrig_env159", int'(env), 159);
    apply(0, 4'd7, 0, 0, 1);
    apply(0, 4'd7, 0, 0, 1);
    chk("resume_sustain", int'(state), int'(SUSTAIN));

    // Reset in SUSTAIN with octave 2 aborts everything at once.
    apply(0, 4'd7, 1, 0, 0);
    apply(0, 4'd7, 1, 0, 0);
    chk("pre_rst_octave", int'(octave), 2);
    chk("pre_rst_env", int'(env), 255);
    apply(1, 4'd7, 0, 1, 1);
    chk("rst_env", int'(env), 0);
    chk("rst_state", int'(state), int'(IDLE));
    chk("rst_octave", int'(octave), 0);
    chk("rst_wave", int'(wave_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_note_on", int'(note_on), 0);
    chk("rst_note", int'(note), 0);

    // Interleaved mode/sound edges leave the FSM alone.
    for (int i = 0; i < 9; i++) begin
      apply(0, 4'd15, (i % 2) == 0, (i % 2) == 1, 1);
      if ((i % 2) == 0) chk("octave_seq", int'(octave), (i / 2 + 1) % 4);
      else chk("wave_seq", int'(wave_sel), (i / 2 + 1) % 4);
      chk("edge_state_idle", int'(state), int'(IDLE));
      chk("edge_env_zero", int'(env), 0);
    end

    // Keycode 13 is a release, both from IDLE and from SUSTAIN.
    apply(0, 4'd13, 0, 0, 0);
    chk("k13_idle_no_pulse", int'(note_on), 0);
    chk("k13_idle_state", int'(state), int'(IDLE));
    apply(0, 4'd2, 1, 0, 0);
    chk("press_with_mode_pulse", int'(note_on), 1);
    chk("press_with_mode_octave", int'(octave), 2);
    for (int i = 0; i < 4; i++) apply(0, 4'd2, 0, 0, 1);
    chk("k2_sustain", int'(state), int'(SUSTAIN));
    apply(0, 4'd2, 0, 0, 0);
    chk("held_no_pulse", int'(note_on), 0);
    apply(0, 4'd13, 0, 0, 0);
    chk("k13_release", int'(state), int'(RELEASE));
    for (int i = 0; i < 8; i++) apply(0, 4'd15, 0, 0, 1);
    chk("drained_idle", int'(state), int'(IDLE));

    // Tick coincident with release in ATTACK: increment applied, then RELEASE.
    apply(0, 4'd3, 0, 0, 0);
    apply(0, 4'd15, 0, 0, 1);
    chk("tick_rel_env", int'(env), 64);
    chk("tick_rel_state", int'(state), int'(RELEASE));
    apply(0, 4'd15, 0, 0, 1);
    apply(0, 4'd15, 0, 0, 1);
    chk("tick_rel_idle", int'(state), int'(IDLE));
    chk("tick_rel_note_kept", int'(note), 3);

    // Randomized run against the model.
    for (int c = 0; c < 800; c++) begin
      logic [3:0] kc;
      int r;
      r  = $urandom_range(0, 9);
      kc = keycode;
      if (r >= 6 && r <= 7) kc = 4'($urandom_range(0, 12));
      else if (r >= 8) kc = 4'($urandom_range(13, 15));
      apply($urandom_range(0, 199) == 0, kc, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
Sequences the synth voice datapath from keypad encoder events. It consumes the encoder's keycode, mode_edge and sound_edge outputs. It latches the active note and runs a single-voice attack/sustain/release envelope FSM paced by a sample-rate tick. It also maintains octave and waveform selection registers for the oscillator and wave-shaper stages downstream.

Parameters:
ENV_W, 8, envelope amplitude width; full scale ENV_MAX = 2^ENV_W - 1
ATTACK_STEP, 64, envelope increment per sample_tick in ATTACK
RELEASE_STEP, 32, envelope decrement per sample_tick in RELEASE

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
keycode  input  4  encoder keycode; 0..12 = key held, 13..15 = no key (15 nominal)
mode_edge  input  1  one-cycle pulse; advance octave
sound_edge  input  1  one-cycle pulse; advance waveform
sample_tick  input  1  one-cycle strobe at sample rate; envelope steps only on this
note  output  4  latched note index 0..12
octave  output  2  octave select 0..3
wave_sel  output  2  waveform select 0..3
env  output  ENV_W  envelope amplitude
note_on  output  1  one-cycle pulse when a note is latched (new or retrigger)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at a clk edge) forces: state IDLE, note 0, octave 0, wave_sel 0, env 0, note_on 0, busy 0. A reset mid-envelope aborts immediately, with no release phase.
- Key validity: keycode <= 12 is valid. Values 13, 14 and 15 all mean released.
- Latency: inputs sampled at edge n are reflected in the registered outputs after edge n. All outputs are registered, with no combinational input-to-output path.
- octave: +1 mod 4 on each mode_edge. wave_sel: +1 mod 4 on each sound_edge. Both are independent of the FSM and update in any state. 3 wraps to 0.
- Envelope arithmetic runs on sample_tick only, using the current (pre-transition) state:
  - ATTACK: env = min(env + ATTACK_STEP, ENV_MAX).
  - RELEASE: env = max(env - RELEASE_STEP, 0), computed without underflow.
  - IDLE and SUSTAIN: no change. SUSTAIN holds ENV_MAX.
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE. Next-state priority within a cycle: key release > key change/press > envelope threshold.
  - IDLE: valid key -> latch note, pulse note_on, go to ATTACK. env starts from 0.
  - ATTACK:
    - Key released -> RELEASE.
    - Valid key != note -> latch new note, pulse note_on, stay in ATTACK. env is not reset (legato).
    - Otherwise, if this cycle's update reaches ENV_MAX -> SUSTAIN.
  - SUSTAIN:
    - Key released -> RELEASE.
    - Valid key != note -> latch new note, pulse note_on, stay in SUSTAIN.
  - RELEASE:
    - Valid key (any, including the same note) -> latch note, pulse note_on, go to ATTACK. Attack resumes from the current env.
    - Otherwise, if this cycle's update reaches 0 -> IDLE.
- Simultaneous events:
  - tick + release in ATTACK: env takes the attack increment and state goes to RELEASE.
  - tick + key change: env updates per the current state and the note is latched.
  - mode_edge/sound_edge coincident with any FSM event: both take effect.
- Steady valid keycode: the same note held continuously produces no further note_on pulses.
- note holds its last value through RELEASE and IDLE, so the release tail plays the old pitch.

Decomposition:
- Shared package synth_pkg holds:
  - env_state_t enum {IDLE, ATTACK, SUSTAIN, RELEASE};
  - constants KEY_NONE = 4'hF and KEY_MAX = 4'd12;
  - a 2-bit octave_t/wave_t typedef reused by the oscillator and wave-shaper.
- One natural sub-module, env_ramp: a parameterised saturating up/down step unit. Its inputs are env, step, dir and en; its outputs are next_env and at_limit. It is instantiated once.

Test Plan:
- Reset during SUSTAIN (env=255, octave=2) with rst=1 for one edge -> env=0, state IDLE, octave=0, wave_sel=0, busy=0, note_on=0 on the next cycle.
- keycode 4'd4 from IDLE, then 4 sample_ticks (defaults) -> note_on pulses for exactly 1 cycle. env goes 64,128,192,255. State is SUSTAIN after the 4th tick and busy=1.
- In SUSTAIN, keycode -> 15, then 8 ticks -> env goes 223,191,...,31,0. State is IDLE on the cycle after the 8th tick. note stays 4 throughout.
- Retrigger: during ATTACK at env=128, keycode 4->7 -> note=7 with a 1-cycle note_on. env continues to 192 and 255 without resetting to 0. Repeat in RELEASE at env=95 -> state ATTACK and env steps to 159.
- 5 mode_edge pulses and 4 sound_edge pulses interleaved -> octave sequence 1,2,3,0,1 and wave_sel sequence 1,2,3,0. The FSM and env are unaffected.
- keycode=13 or 14 from IDLE -> no note_on and state stays IDLE. Keycode 13 in SUSTAIN acts as a release and the state goes to RELEASE.
